// File: rtl/aes_pkg.sv
// Shared AES types, round count and GF(2^8) helpers for the iterative AES-128 sequencer.
// The S-box is computed as the field inverse plus the affine map, so no lookup ROM is needed.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_ctrl_state_t;

  localparam int unsigned AES128_NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] p;
    y = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      y = gf_mul(y, p);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Plaintext-in / ciphertext-out valid/ready bundle for aes_round_ctrl.
// The slave modport is the controller side.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_block_t in_data;
  logic       out_valid;
  logic       out_ready;
  aes_block_t out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on the final round),
// then AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t state_in,
  input  aes_block_t rk,
  input  logic       final_round,
  output aes_block_t state_out
);

  aes_block_t sb, sr, mc;

  sub_bytes u_sub_bytes (
    .data_i (state_in),
    .data_o (sb)
  );

  shift_rows u_shift_rows (
    .data_i (sb),
    .data_o (sr)
  );

  mix_columns u_mix_columns (
    .data_i (sr),
    .data_o (mc)
  );

  assign state_out = (final_round ? sr : mc) ^ rk;

endmodule

// File: rtl/mix_columns.sv
// Combinational MixColumns over the four 32-bit state columns.
module mix_columns
  import aes_pkg::*;
(
  input  aes_block_t data_i,
  output aes_block_t data_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam int unsigned Top = 127 - 32 * c;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_i[Top      -: 8];
    assign a1 = data_i[Top - 8  -: 8];
    assign a2 = data_i[Top - 16 -: 8];
    assign a3 = data_i[Top - 24 -: 8];
    assign data_o[Top      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign data_o[Top - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign data_o[Top - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign data_o[Top - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/shift_rows.sv
// Combinational ShiftRows; byte r+4c sits at [127-8(r+4c) -: 8] (column-major state).
module shift_rows
  import aes_pkg::*;
(
  input  aes_block_t data_i,
  output aes_block_t data_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign data_o[127-8*(r+4*c) -: 8] = data_i[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// Combinational SubBytes: S-box applied to each of the 16 state bytes.
module sub_bytes
  import aes_pkg::*;
(
  input  aes_block_t data_i,
  output aes_block_t data_o
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per clock, round keys fetched by index.
// Optional AES_CTRL_ABORT_EN adds an abort input that drops the block in flight.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES128_NR
) (
  input  logic              clk,
  input  logic              n_rst,
  aes_round_ctrl_if.slave   io,
  output logic [3:0]        rk_idx,
  input  aes_block_t        rk_data,
  output logic              busy
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned RoundW = $clog2(NR + 1);

  aes_ctrl_state_t   state_q, state_d;
  logic [RoundW-1:0] round_q, round_d;
  aes_block_t        data_q, data_d;
  aes_block_t        round_out;
  logic              final_round;

  assign final_round = (round_q == RoundW'(NR));

  aes_round u_aes_round (
    .state_in    (data_q),
    .rk          (rk_data),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          data_d  = io.in_data ^ rk_data;
          round_d = RoundW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = round_out;
        if (final_round) begin
          state_d = DONE;
        end else begin
          round_d = round_q + RoundW'(1);
        end
      end
      DONE: begin
        // Ciphertext stays in data_q after the handshake until the next accept.
        if (io.out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_CTRL_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      round_d = '0;
      data_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  // rk_idx depends only on registered state so the key-store path stays loop-free.
  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
    io.out_data  = data_q;
    busy         = (state_q != IDLE);
    rk_idx       = (state_q == ROUND) ? 4'(round_q) : 4'd0;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: log-table AES reference, cycle-age model checked every cycle,
// FIPS-197 literal vectors, backpressure, mid-block reset, back-to-back and random traffic.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;
`ifdef AES_CTRL_ABORT_EN
  logic         abort;
`endif

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(NR)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .io      (bus.slave),
    .rk_idx  (rk_idx),
    .rk_data (rk_data),
    .busy    (busy)
`ifdef AES_CTRL_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]   sb [256];
  logic [7:0]   ex [256];
  int           lg [256];
  logic [127:0] rk_tab [16];

  assign rk_data = rk_tab[rk_idx];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return ex[(lg[a] + lg[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    ex[0] = 8'h01;
    for (int i = 1; i < 256; i++) ex[i] = ex[i-1] ^ xt(ex[i-1]);
    for (int i = 0; i < 255; i++) lg[ex[i]] = i;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = s;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++)
      rk_tab[k] = (k <= NR) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] res;
    k = rk_tab[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul(8'd2, a0) ^ mul(8'd3, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul(8'd2, a1) ^ mul(8'd3, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul(8'd2, a2) ^ mul(8'd3, a3);
          s[4*c+3] = mul(8'd3, a0) ^ a1 ^ a2 ^ mul(8'd2, a3);
        end
      end
      k = rk_tab[r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Model: a block is "active" from its accept edge; m_age counts edges since then.
  bit           m_on = 1'b0;
  bit           m_active = 1'b0;
  int           m_age = 0;
  logic [127:0] m_ct = '0;
  logic [127:0] m_last = '0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_on     = 1'b1;
      m_active = 1'b0;
      m_last   = '0;
    end else if (m_on) begin
`ifdef AES_CTRL_ABORT_EN
      if (abort && m_active) begin
        m_active = 1'b0;
        m_last   = '0;
      end else
`endif
      if (!m_active) begin
        if (bus.in_valid) begin
          m_active = 1'b1;
          m_age    = 0;
          m_ct     = aes_enc(bus.in_data);
        end
      end else if (m_age < NR) begin
        m_age++;
      end else if (bus.out_ready) begin
        m_active = 1'b0;
        m_last   = m_ct;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_in_ready", bus.in_ready, !m_active);
      chk("m_out_valid", bus.out_valid, m_active && m_age == NR);
      chk("m_busy", busy, m_active);
      chk("m_rk_idx", rk_idx, (m_active && m_age < NR) ? m_age + 1 : 0);
      if (!m_active) chk("m_out_data_idle", bus.out_data, m_last);
      else if (m_age == NR) chk("m_out_data_done", bus.out_data, m_ct);
    end
  end

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk(name, bus.out_valid, 1'b1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    int           tout [4];
    int           nin, nout, cyc, lat;
    logic [127:0] held;

    build_tables();
    n_rst         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
`endif

    set_key(KeyB);
    chk("model_fips_b", aes_enc(PtB), CtB);
    set_key(KeyC);
    chk("model_fips_c1", aes_enc(PtC), CtC);

    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rk_idx", rk_idx, 4'd0);
    chk("rst_out_data", bus.out_data, 128'h0);
    n_rst = 1'b1;

    // FIPS-197 C.1 with round-key index sequence.
    chk("c1_rk_idx_accept", rk_idx, 4'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = PtC;
    step();
    bus.in_valid = 1'b0;
    for (int j = 1; j <= NR; j++) begin
      chk($sformatf("c1_rk_idx_%0d", j), rk_idx, j);
      step();
    end
    chk("c1_out_valid", bus.out_valid, 1'b1);
    chk("c1_out_data", bus.out_data, CtC);
    drain();

    // FIPS-197 B with latency measurement.
    set_key(KeyB);
    bus.in_valid = 1'b1;
    bus.in_data  = PtB;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("b_latency", lat, 11);
    chk("b_out_data", bus.out_data, CtB);
    drain();
    chk("b_held_after_hs", bus.out_data, CtB);

    // Backpressure with in_valid held high throughout.
    bus.in_valid = 1'b1;
    bus.in_data  = PtB;
    step();
    wait_valid("bp_valid");
    held = bus.out_data;
    for (int i = 0; i < 20; i++) begin
      chk("bp_data_stable", bus.out_data, held);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      step();
    end
    chk("bp_data", bus.out_data, CtB);
    drain();
    chk("bp_idle_after_hs", bus.in_ready, 1'b1);
    step();
    chk("bp_second_accept", busy, 1'b1);
    bus.in_valid = 1'b0;
    wait_valid("bp_second_valid");
    chk("bp_second_data", bus.out_data, CtB);
    drain();

    // Reset in round 5, then a clean block.
    bus.in_valid = 1'b1;
    bus.in_data  = PtB;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("mid_rk_idx5", rk_idx, 4'd5);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    chk("mid_in_ready", bus.in_ready, 1'b1);
    chk("mid_out_valid", bus.out_valid, 1'b0);
    chk("mid_out_data", bus.out_data, 128'h0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_valid("mid_after_valid");
    chk("mid_after_data", bus.out_data, CtB);
    drain();

    // Back-to-back with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      cts[i] = aes_enc(pts[i]);
    end
    nin = 0;
    nout = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    while (nout < 4 && cyc < 200) begin
      if (bus.in_ready) begin
        if (nin < 4) begin
          bus.in_data  = pts[nin];
          bus.in_valid = 1'b1;
          nin++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        chk($sformatf("b2b_ct_%0d", nout), bus.out_data, cts[nout]);
        tout[nout] = cyc;
        nout++;
      end
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_count", nout, 4);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_spacing_%0d", i), tout[i] - tout[i-1], 12);

`ifdef AES_CTRL_ABORT_EN
    bus.in_valid = 1'b1;
    bus.in_data  = PtB;
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    chk("abort_rk_idx3", rk_idx, 4'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_r3_in_ready", bus.in_ready, 1'b1);
    chk("abort_r3_out_data", bus.out_data, 128'h0);
    for (int i = 0; i < 15; i++) begin
      chk("abort_r3_no_valid", bus.out_valid, 1'b0);
      step();
    end
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_valid("abort_done_valid");
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    abort         = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_done_in_ready", bus.in_ready, 1'b1);
    chk("abort_done_out_valid", bus.out_valid, 1'b0);
    chk("abort_done_out_data", bus.out_data, 128'h0);
`endif

    // Random traffic with occasional resets, checked by the model process.
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    set_key({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom % 2) == 0;
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = ($urandom % 3) != 0;
      n_rst         = ($urandom % 150) != 0;
`ifdef AES_CTRL_ABORT_EN
      abort         = ($urandom % 60) == 0;
`endif
      step();
    end
    n_rst         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
